// File: rtl/spi_drv_arbiter_if.sv
// Requester and spi_drv side bundle of the shared SPI arbiter.
// slave: arbiter view, master: requesters plus spi_drv view.
interface spi_drv_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int SPI_MAXLEN = 32
);
  localparam int NW = $clog2(SPI_MAXLEN) + 1;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*NW-1:0]         req_n_clks;
  logic [NUM_REQ*SPI_MAXLEN-1:0] req_tx_data;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [SPI_MAXLEN-1:0]         rsp_data;
  logic                          rsp_err;
  logic                          start_cmd;
  logic                          spi_drv_rdy;
  logic [NW-1:0]                 n_clks;
  logic [SPI_MAXLEN-1:0]         tx_data;
  logic [SPI_MAXLEN-1:0]         rx_miso;
  logic [NUM_REQ-1:0]            cs_n;
  logic                          busy;

  modport slave (
    input  req_valid, req_n_clks, req_tx_data,
    input  spi_drv_rdy, rx_miso,
    output req_ready, rsp_valid, rsp_data, rsp_err,
    output start_cmd, n_clks, tx_data, cs_n, busy
  );

  modport master (
    output req_valid, req_n_clks, req_tx_data,
    output spi_drv_rdy, rx_miso,
    input  req_ready, rsp_valid, rsp_data, rsp_err,
    input  start_cmd, n_clks, tx_data, cs_n, busy
  );
endinterface

// File: rtl/spi_drv_arbiter.sv
// Round-robin sharing of one spi_drv master among NUM_REQ requesters,
// with per-requester chip select and setup/hold guard times.
module spi_drv_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int SPI_MAXLEN  = 32,
  parameter int CS_SETUP    = 2,
  parameter int CS_HOLD     = 2,
  parameter int ACK_TIMEOUT = 16
) (
  input logic              clk,
  input logic              sresetn,
  spi_drv_arbiter_if.slave bus
);

  localparam int NW = $clog2(SPI_MAXLEN) + 1;
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int M1 = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int CM = (M1 > ACK_TIMEOUT) ? M1 : ACK_TIMEOUT;
  localparam int CW = $clog2(CM + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_SETUP,
    S_START,
    S_BUSY,
    S_HOLD,
    S_RESP
  } state_e;

  state_e                state_q, state_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [IW-1:0]         gnt_q, gnt_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [NUM_REQ-1:0]    req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [SPI_MAXLEN-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  start_cmd_q, start_cmd_d;
  logic [NW-1:0]         n_clks_q, n_clks_d;
  logic [SPI_MAXLEN-1:0] tx_data_q, tx_data_d;
  logic [NUM_REQ-1:0]    cs_n_q, cs_n_d;
  logic                  busy_q, busy_d;

  logic [NW-1:0]         n_arr  [NUM_REQ];
  logic [SPI_MAXLEN-1:0] tx_arr [NUM_REQ];
  logic [IW-1:0]         pick;
  logic [IW-1:0]         idx;
  logic                  found;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      n_arr[i]  = bus.req_n_clks[i*NW +: NW];
      tx_arr[i] = bus.req_tx_data[i*SPI_MAXLEN +: SPI_MAXLEN];
    end
  end

  // search starts one past the last owner
  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IW'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = 1'b0;
    start_cmd_d = start_cmd_q;
    n_clks_d    = n_clks_q;
    tx_data_d   = tx_data_q;
    cs_n_d      = cs_n_q;
    unique case (state_q)
      S_IDLE: begin
        if (found && bus.spi_drv_rdy) begin
          req_ready_d[pick] = 1'b1;
          gnt_d     = pick;
          ptr_d     = pick;
          n_clks_d  = n_arr[pick];
          tx_data_d = tx_arr[pick];
          state_d   = S_GRANT;
        end
      end
      S_GRANT: begin
        if (n_clks_q == '0 ||
            n_clks_q > NW'(SPI_MAXLEN)) begin
          rsp_valid_d[gnt_q] = 1'b1;
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
          state_d    = S_RESP;
        end else begin
          cs_n_d[gnt_q] = 1'b0;
          cnt_d   = '0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == CW'(CS_SETUP - 1)) begin
          start_cmd_d = 1'b1;
          cnt_d   = '0;
          state_d = S_START;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_START: begin
        if (!bus.spi_drv_rdy) begin
          start_cmd_d = 1'b0;
          state_d = S_BUSY;
        end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
          start_cmd_d = 1'b0;
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_BUSY: begin
        if (bus.spi_drv_rdy) begin
          rsp_data_d = bus.rx_miso;
          cnt_d   = '0;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (cnt_q == CW'(CS_HOLD - 1)) begin
          cs_n_d = '1;
          rsp_valid_d[gnt_q] = 1'b1;
          rsp_err_d = err_q;
          if (err_q) rsp_data_d = '0;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      state_q     <= S_IDLE;
      ptr_q       <= IW'(NUM_REQ - 1);
      gnt_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      start_cmd_q <= 1'b0;
      n_clks_q    <= '0;
      tx_data_q   <= '0;
      cs_n_q      <= '1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      start_cmd_q <= start_cmd_d;
      n_clks_q    <= n_clks_d;
      tx_data_q   <= tx_data_d;
      cs_n_q      <= cs_n_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.start_cmd = start_cmd_q;
  assign bus.n_clks    = n_clks_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.cs_n      = cs_n_q;
  assign bus.busy      = busy_q;

endmodule

// File: doc/spi_drv_arbiter.md
Name: spi_drv_arbiter

Overview:
- Shares one spi_drv master among NUM_REQ requesters using round-robin arbitration.
- Sequences the spi_drv command handshake: start_cmd asserted, spi_drv_rdy 1->0 acknowledges, spi_drv_rdy 0->1 completes.
- Generates one active-low chip select per requester, with programmable setup and hold guard times.
- Returns the captured rx_miso word to the granted requester.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- SPI_MAXLEN, 32, max transfer length; must match spi_drv.
- CS_SETUP, 2, clk cycles from cs_n low to start_cmd high (>=1).
- CS_HOLD, 2, clk cycles from completion to cs_n high (>=1).
- ACK_TIMEOUT, 16, clk cycles start_cmd may wait for spi_drv_rdy to fall before error.

Ports:
- clk  in  1  system clock.
- sresetn  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester request; held stable until matching req_ready.
- req_ready  out  NUM_REQ  one-cycle accept pulse, one-hot.
- req_n_clks  in  NUM_REQ*($clog2(SPI_MAXLEN)+1)  packed bit counts; requester i at slice i.
- req_tx_data  in  NUM_REQ*SPI_MAXLEN  packed tx words; requester i at slice i.
- rsp_valid  out  NUM_REQ  one-cycle completion pulse to the owning requester.
- rsp_data  out  SPI_MAXLEN  received word; valid with rsp_valid, held until next rsp.
- rsp_err  out  1  qualifies rsp_valid: illegal length or ack timeout.
- start_cmd  out  1  to spi_drv.
- spi_drv_rdy  in  1  from spi_drv.
- n_clks  out  $clog2(SPI_MAXLEN)+1  to spi_drv; registered, stable while start_cmd=1.
- tx_data  out  SPI_MAXLEN  to spi_drv; registered, stable while start_cmd=1.
- rx_miso  in  SPI_MAXLEN  from spi_drv.
- cs_n  out  NUM_REQ  per-slave select, active low, at most one low.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async assert, sync release):
  - req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, start_cmd=0.
  - n_clks=0, tx_data=0, cs_n=all 1, busy=0.
  - Round-robin pointer set so requester 0 has highest priority; FSM goes to IDLE.
  - Reset asserted mid-transfer aborts immediately with no rsp_valid. The requester must re-issue.
- All outputs are registered.
- IDLE: if any req_valid=1 and spi_drv_rdy=1, go to GRANT.
- GRANT (1 cycle):
  - Pick the first valid requester at or after ptr+1 mod NUM_REQ; pulse req_ready[g].
  - Latch g, n_clks and tx_data from slice g; set ptr=g.
  - If the latched n_clks is 0 or >SPI_MAXLEN, go to RESP with err=1 and do not touch cs_n or start_cmd. Otherwise drive cs_n[g]=0 and go to SETUP.
- SETUP: count CS_SETUP cycles, then go to START.
- START:
  - start_cmd=1. When spi_drv_rdy is sampled 0, start_cmd=0 next cycle and go to BUSY.
  - If ACK_TIMEOUT cycles elapse with spi_drv_rdy still 1, start_cmd=0, set err=1 and go to HOLD.
- BUSY: wait for spi_drv_rdy sampled 1; latch rx_miso into rsp_data that same edge; go to HOLD. There is no timeout in BUSY.
- HOLD: count CS_HOLD cycles with cs_n[g] still low, then set cs_n=all 1 and go to RESP.
- RESP (1 cycle): rsp_valid[g]=1, rsp_err=err; err clears; go to IDLE.
  - On error, rsp_data=0.
  - A new GRANT cannot occur before the cycle after RESP.
- Requests:
  - Withdrawing req_valid before grant is legal; no response is generated.
  - A requester with req_valid held continuously is re-granted only after all other valid requesters have been served.
- Simultaneous requests: round-robin order only; no fixed priority after reset.
- spi_drv_rdy=0 while in IDLE: no grant until it returns to 1.
- Latency with legal n_clks, no contention: req_valid -> start_cmd high = 2+CS_SETUP cycles.

Test Plan:
- Single request, req 1, n_clks=8, tx_data=0xA5, slave returns 0x3C -> req_ready[1] pulses once; cs_n=4'b1101 for the whole transfer; start_cmd held until spi_drv_rdy falls; rsp_valid[1] with rsp_data=0x3C, rsp_err=0.
- Reqs 0,2,3 asserted together from reset and held -> grant order 0,2,3 then 0; never two cs_n low at once; each response goes only to its owner.
- req_n_clks=0, and separately 33 -> rsp_err=1 within 3 cycles; start_cmd never asserted; cs_n stays all 1.
- spi_drv model never acknowledges -> start_cmd drops after exactly ACK_TIMEOUT=16 cycles; cs_n released after CS_HOLD; rsp_err=1, rsp_data=0.
- sresetn pulsed low during BUSY -> cs_n=all 1 and start_cmd=0 asynchronously; no rsp_valid; next grant goes to lowest-index valid requester.
- Guard timing with CS_SETUP=3, CS_HOLD=4 -> exactly 3 cycles from cs_n fall to start_cmd rise; exactly 4 cycles from spi_drv_rdy rise to cs_n rise.
